// File: rtl/ssp_tx_fifo_param.sv
// Parametrised SSP transmit FIFO: first-word fall-through, occupancy count, watermark interrupt,
// sticky overflow flag and synchronous flush.
module ssp_tx_fifo_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned LW = $clog2(DEPTH + 1)
) (
  input  logic             PCLK,
  input  logic             CLEAR,
  input  logic             PSEL,
  input  logic             PWRITE,
  input  logic [WIDTH-1:0] PWDATA,
  input  logic             FLUSH,
  input  logic             OVRCLR,
  input  logic [LW-1:0]    TXTHRESH,
  input  logic             NextWord,
  output logic             ValidWord,
  output logic [WIDTH-1:0] TxData,
  output logic [LW-1:0]    TXLEVEL,
  output logic             TXFULL,
  output logic             TXOVR,
  output logic             SSPTXINTR
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             ovr_q, ovr_d;
  logic             write_req, push, pop, overflow, do_push;

  // Status depends only on the count register so it cannot glitch with inputs.
  assign ValidWord = (count_q != '0);
  assign TXFULL    = (count_q == LW'(DEPTH));
  assign TXLEVEL   = count_q;
  assign SSPTXINTR = (count_q <= TXTHRESH);
  assign TXOVR     = ovr_q;
  assign TxData    = ValidWord ? mem[rd_ptr_q] : '0;

  assign write_req = PSEL && PWRITE;
  assign pop       = NextWord && ValidWord;
  assign push      = write_req && (!TXFULL || pop);
  assign overflow  = write_req && TXFULL && !pop && !FLUSH;
  assign do_push   = push && !FLUSH && !CLEAR;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = ovr_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + LW'(1);
      else if (pop && !push) count_d = count_q - LW'(1);
    end
    // A fresh overflow beats a simultaneous clear request.
    if (overflow)    ovr_d = 1'b1;
    else if (OVRCLR) ovr_d = 1'b0;
  end

  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (do_push) mem[wr_ptr_q] <= PWDATA;
  end

endmodule

// File: doc/ssp_tx_fifo_param.md
Name: ssp_tx_fifo_param

Overview:
Parametrised transmit FIFO between the APB-style processor write port and the SSP transmit serialiser. It generalises the fixed 8-bit TX FIFO with configurable width and depth, first-word fall-through output, an occupancy count, and a programmable interrupt watermark. It also adds a sticky overflow flag and a synchronous flush. The processor pushes words with PSEL/PWRITE; the SSP logic pops them with NextWord.

Parameters:
WIDTH, 8, data word width in bits (1..32)
DEPTH, 8, number of entries; power of two, 2..256
LW, $clog2(DEPTH+1), width of level/threshold buses (derived, not overridden)

Ports:
PCLK  input  1  system clock; all state changes on rising edge
CLEAR  input  1  reset; one clock, synchronous, active-high
PSEL  input  1  peripheral select for this FIFO
PWRITE  input  1  write strobe; push when PSEL&&PWRITE
PWDATA  input  WIDTH  write data
FLUSH  input  1  synchronous discard of all stored words
OVRCLR  input  1  clears sticky overflow flag
TXTHRESH  input  LW  interrupt watermark, compared against level
NextWord  input  1  SSP pop request
ValidWord  output  1  FIFO non-empty; TxData valid
TxData  output  WIDTH  head-of-FIFO word (fall-through)
TXLEVEL  output  LW  current occupancy 0..DEPTH
TXFULL  output  1  TXLEVEL==DEPTH
TXOVR  output  1  sticky: a write was dropped because FIFO full
SSPTXINTR  output  1  TXLEVEL <= TXTHRESH

Behaviour:
- Storage: DEPTH x WIDTH array, not reset. Write pointer and read pointer are log2(DEPTH) bits and wrap naturally. Occupancy is held in a separate LW-bit count register.
- Reset (CLEAR=1 at edge): pointers=0, count=0, TXOVR=0. Resulting outputs: ValidWord=0, TxData=0, TXLEVEL=0, TXFULL=0, SSPTXINTR=1 (for any TXTHRESH). CLEAR overrides every other input in that cycle, including mid-stream operation.
- push = PSEL && PWRITE && (!TXFULL || pop). pop = NextWord && ValidWord.
- On push, PWDATA is written at the write pointer and the write pointer increments.
- On pop, the read pointer increments.
- count: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Full with simultaneous write and pop: both are accepted, count stays DEPTH, no overflow.
- Empty with simultaneous write and NextWord: NextWord is ignored (ValidWord=0). The write is accepted and count becomes 1.
- NextWord while empty: no effect, no underflow, no flag.
- Write while full without pop: data is dropped and TXOVR is set at that edge. TXOVR holds until OVRCLR or CLEAR.
- OVRCLR together with a new overflow in the same cycle: set wins, TXOVR=1.
- FLUSH (CLEAR=0): pointers=0, count=0. Any push or pop in the same cycle is ignored. TXOVR is unaffected.
- Latency: a word written at edge N appears on TxData with ValidWord=1 after edge N (zero-cycle fall-through). A pop at edge N presents the next word after edge N.
- TxData = mem[rd_ptr] when ValidWord, else all zeros.
- ValidWord, TXFULL, TXLEVEL and SSPTXINTR are combinational from the count register only (glitch-free w.r.t. inputs). SSPTXINTR additionally depends on TXTHRESH.
- SSPTXINTR compare is unsigned over LW bits. TXTHRESH>=DEPTH forces SSPTXINTR=1 permanently.
- Ordering is strict FIFO across pointer wrap-around.

Test Plan:
- Reset/defaults: WIDTH=8, DEPTH=8, TXTHRESH=2. Assert CLEAR 1 cycle -> ValidWord=0, TxData=8'h00, TXLEVEL=0, TXFULL=0, TXOVR=0, SSPTXINTR=1.
- Fill/order/wrap: write 8'h01..8'h08 -> TXFULL=1, TXLEVEL=8, SSPTXINTR=0. Pop 5, write 8'h09..8'h0D, then pop all -> TxData sequence 01..0D in order; ValidWord drops after the last pop.
- Overflow: fill to 8, then write 8'hAA -> TXOVR=1, TXLEVEL=8, 8'hAA never appears. Pulse OVRCLR -> TXOVR=0. Repeat with OVRCLR during the overflowing write -> TXOVR=1.
- Simultaneous events: full FIFO, write 8'h55 with NextWord -> TXLEVEL stays 8, no overflow, 8'h55 emerges last. Empty FIFO, write 8'h33 with NextWord -> TXLEVEL=1, TxData=8'h33.
- Watermark: TXTHRESH=3, DEPTH=8. Push one at a time -> SSPTXINTR=1 at levels 0..3 and 0 at 4..8. Set TXTHRESH=8 -> SSPTXINTR=1 at every level.
- Flush/reset mid-operation: with level 5 and TXOVR=1, assert FLUSH with a concurrent write -> TXLEVEL=0, ValidWord=0, TXOVR=1. Refill 3, then CLEAR with concurrent write and pop -> all reset values; parametrised rerun with WIDTH=16, DEPTH=4 passes the same checks.
